// File: rtl/norl_stat.sv
// norl_stat: per-frame popcount, AND and OR statistics over result words from an upstream NOR stage.
// A frame of FRAME_LEN accepted words is reduced, then held until the consumer takes it.
module norl_stat #(
  parameter int W         = 8,
  parameter int FRAME_LEN = 4,
  localparam int CW       = $clog2(W*FRAME_LEN+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [W-1:0]  y,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] ones,
  output logic [W-1:0]  and_acc,
  output logic [W-1:0]  or_acc,
  output logic          all_zero
);

  localparam int NW = $clog2(FRAME_LEN+1);
  localparam logic [NW-1:0] LAST_CNT = NW'(FRAME_LEN-1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [NW-1:0] count_reg, count_next;
  logic [CW-1:0] ones_reg,  ones_next;
  logic [W-1:0]  and_reg,   and_next;
  logic [W-1:0]  or_reg,    or_next;
  logic [CW-1:0] y_ones;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  assign y_ones    = popcount(y);
  assign in_ready  = (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign all_zero  = out_valid && (or_reg == '0);
  assign ones      = ones_reg;
  assign and_acc   = and_reg;
  assign or_acc    = or_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ones_reg  <= '0;
      and_reg   <= '0;
      or_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ones_reg  <= ones_next;
      and_reg   <= and_next;
      or_reg    <= or_next;
    end
  end

  // clr outranks both an accept and a release, so it is decoded ahead of the state case.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ones_next  = ones_reg;
    and_next   = and_reg;
    or_next    = or_reg;
    if (clr) begin
      state_next = IDLE;
      count_next = '0;
      ones_next  = '0;
      and_next   = '0;
      or_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ones_next  = y_ones;
            and_next   = y;
            or_next    = y;
            count_next = NW'(1);
            state_next = (FRAME_LEN == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            ones_next  = ones_reg + y_ones;
            and_next   = and_reg & y;
            or_next    = or_reg | y;
            count_next = count_reg + NW'(1);
            if (count_reg == LAST_CNT) state_next = HOLD;
          end
        end
        HOLD: begin
          // A released frame leaves empty partials behind for the next one.
          if (out_ready) begin
            state_next = IDLE;
            count_next = '0;
            ones_next  = '0;
            and_next   = '0;
            or_next    = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norl_stat.sv
// Self-checking bench for norl_stat: directed scenarios plus random frames against a queue-based model.
module tb_norl_stat;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] y = 8'h00;
  logic       in_ready, out_valid, all_zero;
  logic [5:0] ones;
  logic [7:0] and_acc, or_acc;

  logic       clr1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic       out_ready1 = 1'b0;
  logic [7:0] y1 = 8'h00;
  logic       in_ready1, out_valid1, all_zero1;
  logic [3:0] ones1;
  logic [7:0] and_acc1, or_acc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  norl_stat #(.W(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .y(y), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .ones(ones), .and_acc(and_acc), .or_acc(or_acc), .all_zero(all_zero)
  );

  norl_stat #(.W(8), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .y(y1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ones(ones1), .and_acc(and_acc1), .or_acc(or_acc1), .all_zero(all_zero1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame statistics straight from their definitions.
  function automatic void model(input logic [7:0] q[$], output int o,
                                output logic [7:0] a, output logic [7:0] r);
    o = 0;
    a = 8'hFF;
    r = 8'h00;
    foreach (q[k]) begin
      o += $countones(q[k]);
      a &= q[k];
      r |= q[k];
    end
  endfunction

  task automatic chk_out(input string tag, input bit ov, input int o,
                         input logic [7:0] a, input logic [7:0] r, input bit az);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " in_ready"},  32'(in_ready),  32'(!ov));
    chk({tag, " ones"},      32'(ones),      o);
    chk({tag, " and_acc"},   32'(and_acc),   32'(a));
    chk({tag, " or_acc"},    32'(or_acc),    32'(r));
    chk({tag, " all_zero"},  32'(all_zero),  32'(az));
  endtask

  task automatic chk_out1(input string tag, input logic [7:0] w);
    chk({tag, " out_valid"}, 32'(out_valid1), 32'd1);
    chk({tag, " in_ready"},  32'(in_ready1),  32'd0);
    chk({tag, " ones"},      32'(ones1),      $countones(w));
    chk({tag, " and_acc"},   32'(and_acc1),   32'(w));
    chk({tag, " or_acc"},    32'(or_acc1),    32'(w));
    chk({tag, " all_zero"},  32'(all_zero1),  32'(w == 8'h00));
  endtask

  // Feed one frame with random idle gaps, check partials, the held result and the release.
  task automatic play_frame(input string tag, input logic [7:0] w[$], input int gmin,
                            input int gmax, input int hold, input bit busy_in_hold);
    logic [7:0] pre[$];
    int         o;
    logic [7:0] a, r;
    out_ready = (hold == 0);
    foreach (w[i]) begin
      repeat ($urandom_range(gmax, gmin)) begin
        in_valid = 1'b0;
        y = 8'($urandom);
        tick();
        if (i > 0) chk_out({tag, " gap"}, 1'b0, o, a, r, 1'b0);
      end
      in_valid = 1'b1;
      y = w[i];
      tick();
      pre.push_back(w[i]);
      model(pre, o, a, r);
      if (i < w.size() - 1) chk_out({tag, " partial"}, 1'b0, o, a, r, 1'b0);
    end
    in_valid = 1'b0;
    chk_out({tag, " result"}, 1'b1, o, a, r, r == 8'h00);
    repeat (hold) begin
      in_valid = busy_in_hold;
      y = 8'($urandom);
      tick();
      chk_out({tag, " hold"}, 1'b1, o, a, r, r == 8'h00);
    end
    in_valid = (hold != 0);
    y = 8'hAA;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, " release out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " release in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] w;

    #1;
    chk_out("reset", 1'b0, 0, 8'h00, 8'h00, 1'b0);
    chk("reset dut1 in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    q = '{8'h0F, 8'h00, 8'h05, 8'hFF};
    play_frame("b2b", q, 0, 0, 0, 1'b0);
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    play_frame("zeros", q, 0, 1, 1, 1'b0);
    q = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
    play_frame("gaps", q, 1, 3, 5, 1'b1);

    // clr after two words, asserted together with a valid word
    repeat (2) begin
      in_valid = 1'b1;
      y = 8'($urandom);
      tick();
    end
    clr = 1'b1;
    y = 8'h33;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk_out("clr accum", 1'b0, 0, 8'h00, 8'h00, 1'b0);
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    play_frame("after clr", q, 0, 0, 2, 1'b0);

    // clr in HOLD beats a simultaneous out_ready and discards the result
    repeat (4) begin
      in_valid = 1'b1;
      y = 8'h01;
      tick();
    end
    in_valid = 1'b0;
    chk_out("pre clr hold", 1'b1, 4, 8'h01, 8'h01, 1'b0);
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    chk_out("clr hold", 1'b0, 0, 8'h00, 8'h00, 1'b0);

    // asynchronous reset mid-cycle in ACCUM
    repeat (2) begin
      in_valid = 1'b1;
      y = 8'($urandom) | 8'h01;
      tick();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_out("rst accum", 1'b0, 0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    q = '{8'h81, 8'h42, 8'h24, 8'h18};
    play_frame("post rst accum", q, 0, 1, 1, 1'b0);

    // asynchronous reset mid-cycle in HOLD
    repeat (4) begin
      in_valid = 1'b1;
      y = 8'hF0;
      tick();
    end
    in_valid = 1'b0;
    chk_out("pre rst hold", 1'b1, 16, 8'hF0, 8'hF0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_out("rst hold", 1'b0, 0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    q = '{8'h3C, 8'h7E, 8'h18, 8'hFF};
    play_frame("post rst hold", q, 0, 2, 2, 1'b1);

    // random frames, some biased to all-zero or all-one words
    for (int f = 0; f < 8; f++) begin
      q = {};
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(3, 0))
          0:       w = 8'h00;
          1:       w = 8'hFF;
          default: w = 8'($urandom);
        endcase
        q.push_back(w);
      end
      play_frame($sformatf("rand%0d", f), q, 0, 2, $urandom_range(3, 0), 1'($urandom));
    end

    // single-word frames
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       w = 8'h05;
        1:       w = 8'h00;
        default: w = 8'($urandom);
      endcase
      in_valid1 = 1'b1;
      y1 = w;
      tick();
      in_valid1 = 1'b0;
      chk_out1($sformatf("len1 w%0d", k), w);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk($sformatf("len1 w%0d release out_valid", k), 32'(out_valid1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
